instruktions_holer: RTL



---
 rtl/prozessor_pkg.sv | 18 +
 rtl/naechste_adresse.sv | 31 +++
 rtl/instruktions_holer.sv | 105 ++++++++++
 3 files changed

// File: rtl/prozessor_pkg.sv
// rtl/prozessor_pkg.sv - shared fetch/decode types and constants
package prozessor_pkg;

  // Fetch FSM state encoding
  typedef enum logic [1:0] {
    ANFORDERN  = 2'd0,
    WARTEN     = 2'd1,
    DEKODIEREN = 2'd2,
    AUSFUEHREN = 2'd3
  } zustand_t;

  // Default PC after reset (word address)
  localparam logic [31:0] START_ADRESSE = 32'h0000_0000;

  // Relative jump offset width, same as the decoder's large-immediate field
  localparam int SPRUNG_OFFSET_BREITE = 26;

endpackage

// File: rtl/naechste_adresse.sv
// rtl/naechste_adresse.sv - combinational next-PC adder/mux
module naechste_adresse
  import prozessor_pkg::*;
#(
  parameter int AdressBreite = 32
) (
  input  logic [AdressBreite-1:0]         befehlszaehler,
  input  logic                            sprung_genommen,
  input  logic                            sprung_absolut,
  input  logic [SPRUNG_OFFSET_BREITE-1:0] sprung_offset,
  input  logic [AdressBreite-1:0]         sprung_ziel,
  output logic [AdressBreite-1:0]         naechster_pc
);

  logic [AdressBreite-1:0] offset_ext;

  // Select sequential, absolute or relative target; all sums wrap at the address width
  always_comb begin
    offset_ext   = AdressBreite'($signed(sprung_offset));
    naechster_pc = befehlszaehler + AdressBreite'(1);
    if (sprung_genommen) begin
      if (sprung_absolut) begin
        naechster_pc = sprung_ziel;
      end else begin
        // Offset counts from the jump instruction itself, not from PC+1
        naechster_pc = befehlszaehler + offset_ext;
      end
    end
  end

endmodule

// File: rtl/instruktions_holer.sv
// rtl/instruktions_holer.sv - instruction fetch stage feeding the decoder
module instruktions_holer
  import prozessor_pkg::*;
#(
  parameter int                    AdressBreite = 32,
  parameter logic [AdressBreite-1:0] StartAdresse = AdressBreite'(START_ADRESSE)
) (
  input  logic                            Clock,
  input  logic                            Reset,
  output logic [AdressBreite-1:0]         SpeicherAdresse,
  output logic                            SpeicherLesen,
  input  logic                            SpeicherBereit,
  input  logic [31:0]                     SpeicherDaten,
  output logic [31:0]                     Instruktion,
  output logic                            DekodierSignal,
  output logic [AdressBreite-1:0]         Befehlszaehler,
  input  logic                            Weiter,
  input  logic                            SprungGenommen,
  input  logic                            SprungAbsolut,
  input  logic [SPRUNG_OFFSET_BREITE-1:0] SprungOffset,
  input  logic [AdressBreite-1:0]         SprungZiel
);

  zustand_t                zustand_q, zustand_d;
  logic [AdressBreite-1:0] pc_q, pc_d;
  logic [AdressBreite-1:0] bz_q, bz_d;
  logic [31:0]             instr_q, instr_d;
  logic                    lesen_q, lesen_d;
  logic                    dekod_q, dekod_d;
  logic [AdressBreite-1:0] naechster_pc;

  naechste_adresse #(
    .AdressBreite(AdressBreite)
  ) u_naechste_adresse (
    .befehlszaehler  (bz_q),
    .sprung_genommen (SprungGenommen),
    .sprung_absolut  (SprungAbsolut),
    .sprung_offset   (SprungOffset),
    .sprung_ziel     (SprungZiel),
    .naechster_pc    (naechster_pc)
  );

  // Next-state and next-output logic; every output is taken from a flop
  always_comb begin
    zustand_d = zustand_q;
    pc_d      = pc_q;
    bz_d      = bz_q;
    instr_d   = instr_q;
    lesen_d   = lesen_q;
    dekod_d   = 1'b0;
    case (zustand_q)
      ANFORDERN: begin
        lesen_d   = 1'b1;
        zustand_d = WARTEN;
      end
      WARTEN: begin
        if (SpeicherBereit) begin
          instr_d   = SpeicherDaten;
          bz_d      = pc_q;
          lesen_d   = 1'b0;
          dekod_d   = 1'b1;
          zustand_d = DEKODIEREN;
        end
      end
      DEKODIEREN: begin
        zustand_d = AUSFUEHREN;
      end
      AUSFUEHREN: begin
        if (Weiter) begin
          pc_d      = naechster_pc;
          zustand_d = ANFORDERN;
        end
      end
      default: begin
        zustand_d = ANFORDERN;
      end
    endcase
  end

  // State register with synchronous reset taking priority over all inputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand_q <= ANFORDERN;
      pc_q      <= StartAdresse;
      bz_q      <= StartAdresse;
      instr_q   <= 32'h0;
      lesen_q   <= 1'b0;
      dekod_q   <= 1'b0;
    end else begin
      zustand_q <= zustand_d;
      pc_q      <= pc_d;
      bz_q      <= bz_d;
      instr_q   <= instr_d;
      lesen_q   <= lesen_d;
      dekod_q   <= dekod_d;
    end
  end

  assign SpeicherAdresse = pc_q;
  assign SpeicherLesen   = lesen_q;
  assign Instruktion     = instr_q;
  assign DekodierSignal  = dekod_q;
  assign Befehlszaehler  = bz_q;

endmodule
